fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Round-robin write arbiter sharing one FIFO write port (w_en/data_in/full) among N_REQ producers.
//  Each producer presents a valid/ready stream.
//  One owner at a time holds the port for a burst of up to MAX_BURST words, then ownership rotates.
//  Sits directly in front of the FIFO. The FIFO read side is untouched.
// PARAMETERS
//  N_REQ      4   number of producers (>=2)
//  DATA_W     8   word width, equal to the FIFO data width
//  MAX_BURST  4   max words accepted per grant (>=1)
// PORTS
//  clk           in   1             single clock, all state on posedge
//  rst_n         in   1             asynchronous active-low reset
//  req_valid     in   N_REQ         producer i has a word
//  req_data      in   N_REQ*DATA_W  producer i word in bits [i*DATA_W +: DATA_W]
//  req_ready     out  N_REQ         word of producer i is accepted this cycle
//  fifo_full     in   1             FIFO full flag
//  fifo_w_en     out  1             FIFO write enable
//  fifo_data_in  out  DATA_W        FIFO write data
//  grant_id      out  $clog2(N_REQ) current owner index
//  busy          out  1             a grant is active (state BURST)
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, owner=0, rr_ptr=0, cnt=0.
//   Outputs: req_ready=0, fifo_w_en=0, fifo_data_in=0, grant_id=0, busy=0.
//  FSM states are IDLE and BURST.
//   State, owner, rr_ptr and cnt ($clog2(MAX_BURST+1) bits) are registered.
//  Winner search: first i with req_valid[i], scanning rr_ptr, rr_ptr+1, ... mod N_REQ.
//  IDLE, any req_valid: on the next edge owner=winner, cnt=0, state goes to BURST.
//   No transfer happens in IDLE, so the first word has 1 cycle of latency.
//  BURST outputs are combinational:
//   req_ready[owner] = !fifo_full; all other req_ready bits are 0.
//   fifo_w_en = req_valid[owner] & !fifo_full.
//   fifo_data_in = req_data[owner].
//   Never more than one write per cycle.
//  Transfer = fifo_w_en. A transfer increments cnt.
//  Release at the edge when either condition holds:
//   (a) a transfer happens with cnt==MAX_BURST-1, or
//   (b) req_valid[owner]==0.
//  On release: rr_ptr=owner+1 mod N_REQ, cnt=0.
//   Re-search from the new rr_ptr, using the current cycle's req_valid.
//   Hit: owner=winner, stay in BURST with no bubble cycle.
//   Miss: go to IDLE.
//  The owner is last in the re-search order.
//   If it is the only valid producer, it is re-granted a fresh burst.
//  fifo_full in BURST: no transfer, cnt frozen, owner held.
//   Full never causes a release on its own.
//   Release (b) still applies while full.
//  Producers must hold data stable while valid & !ready. The arbiter never drops or duplicates a word.
//  IDLE: fifo_data_in=0, grant_id holds the last owner, busy=0.
//  Reset mid-burst: outputs clear asynchronously. The partial burst is abandoned.
//   After release, arbitration restarts with rr_ptr=0.
// TESTING
//  1 Reset: rst_n=0 with all req_valid=1
//     -> req_ready=0, fifo_w_en=0, busy=0, grant_id=0, all without a clock edge.
//  2 Only req 1 valid with 6 words, fifo_full=0
//     -> grant_id=1 after 1 cycle, 4 consecutive writes, re-grant to 1 with no gap, 2 more writes, then IDLE.
//  3 All 4 producers continuously valid
//     -> bursts in order 0,1,2,3,0, 4 words each.
//     -> fifo_w_en=1 every cycle after the first.
//     -> fifo_data_in matches the owner's word sequence.
//  4 fifo_full=1 for 3 cycles after the 2nd word of a burst
//     -> w_en=0, ready=0, grant_id unchanged.
//     -> then words 3 and 4 are written, then rotation.
//  5 Owner 0 drops valid after 2 words while req 2 is valid
//     -> next edge grant_id=2, cnt=0, no word lost; FIFO contents in order.
//  6 rst_n pulsed low mid-burst of req 3 with reqs 0 and 3 valid
//     -> outputs clear at once; after release, grant_id=0 first.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: N_REQ valid/ready producers share one
// FIFO write port, each owner keeping it for up to MAX_BURST words.
module fifo_wr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*DATA_W-1:0]    req_data,
    output logic [N_REQ-1:0]           req_ready,
    input  logic                       fifo_full,
    output logic                       fifo_w_en,
    output logic [DATA_W-1:0]          fifo_data_in,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       busy
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [IW-1:0] owner_nxt;
    logic [IW-1:0] search_ptr;
    logic [IW-1:0] win;
    logic          hit;
    logic          xfer;
    logic          release_now;

    // Slot after the current owner; the owner itself is searched last.
    always_comb begin
        if (owner_q == IW'(N_REQ - 1)) begin
            owner_nxt = '0;
        end else begin
            owner_nxt = owner_q + 1'b1;
        end
    end

    // In IDLE search from the stored pointer, in BURST from the
    // pointer a release would install this cycle.
    always_comb begin
        search_ptr = owner_nxt;
        if (state_q == IDLE) begin
            search_ptr = rr_ptr_q;
        end
    end

    // First valid producer scanning upward from search_ptr, wrapping.
    always_comb begin
        win = '0;
        hit = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(search_ptr) + k) % N_REQ]) begin
                win = IW'((int'(search_ptr) + k) % N_REQ);
                hit = 1'b1;
            end
        end
    end

    // Port muxing toward the FIFO; only the owner can ever be ready.
    always_comb begin
        req_ready    = '0;
        fifo_w_en    = 1'b0;
        fifo_data_in = '0;
        if (state_q == BURST) begin
            req_ready[owner_q] = !fifo_full;
            fifo_w_en          = req_valid[owner_q] & !fifo_full;
            fifo_data_in       = req_data[int'(owner_q)*DATA_W +: DATA_W];
        end
    end

    assign xfer        = fifo_w_en;
    assign release_now = (xfer && (cnt_q == CW'(MAX_BURST - 1)))
                       || !req_valid[owner_q];

    // Grant, burst counting and rotation; a release regrants in the
    // same edge so back-to-back bursts have no bubble.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (hit) begin
                    owner_d = win;
                    cnt_d   = '0;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (release_now) begin
                    rr_ptr_d = owner_nxt;
                    cnt_d    = '0;
                    if (hit) begin
                        owner_d = win;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (xfer) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign grant_id = owner_q;
    assign busy     = (state_q == BURST);

    a_ready_onehot: assert property (
        @(posedge clk) disable iff (!rst_n) $onehot0(req_ready));

    a_cnt_bound: assert property (
        @(posedge clk) disable iff (!rst_n) cnt_q < CW'(MAX_BURST));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus random traffic,
// each cycle compared against a transaction-level arbiter model.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MB = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           fifo_full;
    logic           fifo_w_en;
    logic [W-1:0]   fifo_data_in;
    logic [1:0]     grant_id;
    logic           busy;

    fifo_wr_arbiter #(
        .N_REQ    (N),
        .DATA_W   (W),
        .MAX_BURST(MB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .fifo_full   (fifo_full),
        .fifo_w_en   (fifo_w_en),
        .fifo_data_in(fifo_data_in),
        .grant_id    (grant_id),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;
    int en[N];
    int left[N];
    int seq[N];
    bit full_r;
    int dut_wr;

    // reference model: who holds the port and how many words it has moved
    bit m_busy;
    int m_owner;
    int m_rr;
    int m_cnt;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp,
                     $time);
        end
    endtask

    function automatic logic [7:0] word(input int i);
        return 8'((i << 6) | (seq[i] & 63));
    endfunction

    function automatic int pick(input int start);
        for (int k = 0; k < N; k++) begin
            if (req_valid[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = (en[i] != 0) && (left[i] > 0);
            req_data[i*W +: W] = word(i);
        end
        fifo_full = full_r;
    endtask

    task automatic model_reset();
        m_busy  = 0;
        m_owner = 0;
        m_rr    = 0;
        m_cnt   = 0;
    endtask

    task automatic cycle();
        logic [N-1:0] e_rdy;
        bit           e_wen;
        logic [7:0]   e_data;
        bit           xf;
        bit           rel;
        int           w;
        drive();
        @(negedge clk);
        e_rdy  = (m_busy && !full_r) ? (N'(1) << m_owner) : '0;
        e_wen  = m_busy && req_valid[m_owner] && !full_r;
        e_data = m_busy ? word(m_owner) : 8'h00;
        chk("ready", 32'(req_ready), 32'(e_rdy));
        chk("w_en", 32'(fifo_w_en), 32'(e_wen));
        chk("data", 32'(fifo_data_in), 32'(e_data));
        chk("grant", 32'(grant_id), 32'(m_owner));
        chk("busy", 32'(busy), 32'(m_busy));
        if (fifo_w_en) dut_wr++;
        for (int i = 0; i < N; i++) begin
            if (e_rdy[i] && req_valid[i]) begin
                left[i]--;
                seq[i]++;
            end
        end
        if (!m_busy) begin
            w = pick(m_rr);
            if (w >= 0) begin
                m_owner = w;
                m_cnt   = 0;
                m_busy  = 1;
            end
        end else begin
            xf  = e_wen;
            rel = (xf && m_cnt == MB - 1) || !req_valid[m_owner];
            if (xf) m_cnt++;
            if (rel) begin
                m_rr  = (m_owner + 1) % N;
                m_cnt = 0;
                w     = pick(m_rr);
                if (w >= 0) m_owner = w;
                else m_busy = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        drive();
        rst_n = 1'b0;
        #1;
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_w_en", 32'(fifo_w_en), 32'h0);
        chk("rst_data", 32'(fifo_data_in), 32'h0);
        chk("rst_grant", 32'(grant_id), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic set_all(input int e, input int l);
        for (int i = 0; i < N; i++) begin
            en[i]   = e;
            left[i] = l;
        end
    endtask

    initial begin
        int n;
        full_r = 0;
        dut_wr = 0;
        for (int i = 0; i < N; i++) seq[i] = 0;
        // reset with every producer valid
        set_all(1, 1);
        rst_n = 1'b0;
        drive();
        #2;
        chk("t1_ready", 32'(req_ready), 32'h0);
        chk("t1_w_en", 32'(fifo_w_en), 32'h0);
        chk("t1_busy", 32'(busy), 32'h0);
        chk("t1_grant", 32'(grant_id), 32'h0);
        model_reset();
        // lone producer 1 with six words
        set_all(0, 0);
        en[1]   = 1;
        left[1] = 6;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        dut_wr = 0;
        repeat (10) cycle();
        chk("t2_writes", 32'(dut_wr), 32'd6);
        chk("t2_idle", 32'(busy), 32'h0);
        // all four producers streaming
        rst_pulse();
        set_all(1, 40);
        dut_wr = 0;
        repeat (21) cycle();
        chk("t3_writes", 32'(dut_wr), 32'd20);
        set_all(0, 0);
        repeat (2) cycle();
        // FIFO full for three cycles after the 2nd word
        set_all(1, 40);
        repeat (3) cycle();
        full_r = 1;
        repeat (3) cycle();
        full_r = 0;
        repeat (6) cycle();
        set_all(0, 0);
        repeat (2) cycle();
        // owner 0 runs dry after two words while producer 2 waits
        rst_pulse();
        en[0]   = 1;
        left[0] = 2;
        en[2]   = 1;
        left[2] = 4;
        dut_wr  = 0;
        repeat (10) cycle();
        chk("t5_writes", 32'(dut_wr), 32'd6);
        // reset in the middle of producer 3's burst
        rst_pulse();
        set_all(0, 0);
        en[0]   = 1;
        left[0] = 40;
        en[3]   = 1;
        left[3] = 40;
        n = 0;
        while (!(m_busy && m_owner == 3 && m_cnt == 1) && n < 30) begin
            cycle();
            n++;
        end
        chk("t6_reach", 32'(n < 30), 32'd1);
        rst_pulse();
        repeat (2) cycle();
        chk("t6_grant0", 32'(grant_id), 32'd0);
        chk("t6_busy", 32'(busy), 32'd1);
        // random traffic
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                en[i] = ($urandom_range(0, 3) != 0) ? 1 : 0;
                if (left[i] <= 0 && $urandom_range(0, 7) == 0)
                    left[i] = $urandom_range(1, 10);
            end
            full_r = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 499) == 0) rst_pulse();
            else cycle();
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
